// File: rtl/pe_ws_os_if.sv
// pe_ws_os_if: operand, weight, control and result bundle of one systolic PE
// Ports (master drives, slave = PE):
//   mode, in_valid, in_left, in_up          dataflow inputs and mode select
//   w_load, w_in, w_swap                    double-buffered weight load/swap
//   acc_clear, drain                        accumulator control
//   out_right, out_down, out_valid          registered dataflow outputs
//   acc_out, acc_out_valid, ovf             drained accumulator and sticky overflow
interface pe_ws_os_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
);
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_left;
    logic [ACC_W-1:0]  in_up;
    logic              w_load;
    logic [DATA_W-1:0] w_in;
    logic              w_swap;
    logic              acc_clear;
    logic              drain;
    logic [DATA_W-1:0] out_right;
    logic [ACC_W-1:0]  out_down;
    logic              out_valid;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_out_valid;
    logic              ovf;
    modport master (
        output mode, in_valid, in_left, in_up, w_load, w_in, w_swap, acc_clear, drain,
        input  out_right, out_down, out_valid, acc_out, acc_out_valid, ovf
    );
    modport slave (
        input  mode, in_valid, in_left, in_up, w_load, w_in, w_swap, acc_clear, drain,
        output out_right, out_down, out_valid, acc_out, acc_out_valid, ovf
    );
endinterface

// File: rtl/pe_ws_os.sv
// pe_ws_os: systolic PE with double-buffered weight, runtime WS/OS mode, saturating MAC
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset, clears every register
//   bus  pe_ws_os_if slave: dataflow in/out, weight load/swap, accumulator control
module pe_ws_os #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input logic        clk,
    input logic        rst,
    pe_ws_os_if.slave  bus
);
    logic [DATA_W-1:0]   r_shadow_w, r_active_w, r_out_right;
    logic [ACC_W-1:0]    r_acc, r_out_down, r_acc_out;
    logic                r_out_valid, r_acc_out_valid, r_ovf;
    logic [DATA_W-1:0]   w_b;
    logic [2*DATA_W-1:0] w_l_x, w_b_x, w_prod;
    logic [ACC_W-1:0]    w_addend, w_clamp, w_res, w_acc_next;
    logic [ACC_W:0]      w_sum;
    logic                w_zero_acc, w_of;

    assign w_b = bus.mode ? bus.in_up[DATA_W-1:0] : r_active_w;
    // Operands pre-extended to the product width so one multiplier serves both signedness cases
    assign w_l_x = {{DATA_W{(SIGNED != 0) & bus.in_left[DATA_W-1]}}, bus.in_left};
    assign w_b_x = {{DATA_W{(SIGNED != 0) & w_b[DATA_W-1]}}, w_b};
    assign w_prod = w_l_x * w_b_x;
    // Drain/clear restart the accumulation, so a same-cycle valid input lands on zero
    assign w_zero_acc = bus.drain | bus.acc_clear;
    assign w_addend = bus.mode ? (w_zero_acc ? '0 : r_acc) : bus.in_up;
    assign w_sum = {(SIGNED != 0) & w_addend[ACC_W-1], w_addend}
                 + {{(ACC_W+1-2*DATA_W){(SIGNED != 0) & w_prod[2*DATA_W-1]}}, w_prod};
    // One guard bit is enough: the true sum always fits in ACC_W+1 bits
    assign w_of = (SIGNED != 0) ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    assign w_clamp = (SIGNED == 0) ? '1 : {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}};
    assign w_res = (SAT != 0 && w_of) ? w_clamp : w_sum[ACC_W-1:0];
    assign w_acc_next = bus.mode ? (bus.in_valid ? w_res : (w_zero_acc ? '0 : r_acc))
                                 : (bus.acc_clear ? '0 : r_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow_w      <= '0;
            r_active_w      <= '0;
            r_acc           <= '0;
            r_out_right     <= '0;
            r_out_down      <= '0;
            r_out_valid     <= 1'b0;
            r_acc_out       <= '0;
            r_acc_out_valid <= 1'b0;
            r_ovf           <= 1'b0;
        end else begin
            if (bus.w_load) r_shadow_w <= bus.w_in;
            if (bus.w_swap) r_active_w <= r_shadow_w;
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out_right <= bus.in_left;
                r_out_down  <= bus.mode ? bus.in_up : w_res;
            end
            r_acc           <= w_acc_next;
            r_acc_out_valid <= bus.mode & bus.drain;
            if (bus.mode & bus.drain) r_acc_out <= r_acc;
            // A new overflow wins over a same-cycle clear
            r_ovf <= (bus.in_valid & w_of) | (r_ovf & ~bus.acc_clear);
        end
    end

    assign bus.out_right     = r_out_right;
    assign bus.out_down      = r_out_down;
    assign bus.out_valid     = r_out_valid;
    assign bus.acc_out       = r_acc_out;
    assign bus.acc_out_valid = r_acc_out_valid;
    assign bus.ovf           = r_ovf;
endmodule

// File: tb/tb_pe_ws_os.sv
// tb_pe_ws_os: scoreboard bench for three pe_ws_os variants (signed sat, signed wrap, unsigned sat)
module tb_pe_ws_os;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam bit [2:0] SG = 3'b011;
    localparam bit [2:0] ST = 3'b101;

    typedef struct packed {
        logic          ov;
        logic [DW-1:0] orr;
        logic [AW-1:0] od;
        logic          aov;
        logic [AW-1:0] ao;
        logic          ovf;
    } obs_t;
    typedef obs_t [2:0] trio_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0, iv = 1'b0, wl = 1'b0, ws = 1'b0, clr = 1'b0, drn = 1'b0;
    logic [DW-1:0] left = '0, win = '0;
    logic [AW-1:0] up = '0;
    obs_t act [3];
    trio_t q[$];
    int n_vec = 0;
    int n_bad = 0;
    longint m_sh [3];
    longint m_ac [3];
    longint m_acc [3];
    obs_t m_o [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        pe_ws_os_if #(.DATA_W(DW), .ACC_W(AW)) bus ();
        assign bus.mode = mode;
        assign bus.in_valid = iv;
        assign bus.in_left = left;
        assign bus.in_up = up;
        assign bus.w_load = wl;
        assign bus.w_in = win;
        assign bus.w_swap = ws;
        assign bus.acc_clear = clr;
        assign bus.drain = drn;
        pe_ws_os #(.DATA_W(DW), .ACC_W(AW), .SIGNED(int'(SG[g])), .SAT(int'(ST[g]))) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
        assign act[g] = {bus.out_valid, bus.out_right, bus.out_down, bus.acc_out_valid, bus.acc_out, bus.ovf};
    end

    function automatic longint sv(input longint raw, input int w, input bit s);
        return (s && raw[w-1]) ? raw - (longint'(1) << w) : raw;
    endfunction

    function automatic longint fit(input longint sum, input bit s, input bit sat, output bit of);
        longint lo, hi, r;
        lo = s ? -(longint'(1) << (AW-1)) : 0;
        hi = s ? (longint'(1) << (AW-1)) - 1 : (longint'(1) << AW) - 1;
        of = (sum < lo) || (sum > hi);
        r = (of && sat) ? ((sum < lo) ? lo : hi) : sum;
        return r & ((longint'(1) << AW) - 1);
    endfunction

    task automatic model(input int d);
        bit s, sat, of;
        longint b, prod, base, r;
        obs_t o;
        s = SG[d];
        sat = ST[d];
        of = 1'b0;
        o = m_o[d];
        b = mode ? longint'(up[DW-1:0]) : m_ac[d];
        prod = sv(longint'(left), DW, s) * sv(b, DW, s);
        o.aov = mode && drn;
        if (o.aov) o.ao = AW'(m_acc[d]);
        if (iv) begin
            base = mode ? ((drn || clr) ? 0 : sv(m_acc[d], AW, s)) : sv(longint'(up), AW, s);
            r = fit(base + prod, s, sat, of);
            o.orr = left;
            o.od = mode ? up : AW'(r);
            if (mode) m_acc[d] = r;
        end else if (mode && (drn || clr)) m_acc[d] = 0;
        if (!mode && clr) m_acc[d] = 0;
        o.ov = iv;
        o.ovf = of || (o.ovf && !clr);
        if (ws) m_ac[d] = m_sh[d];
        if (wl) m_sh[d] = longint'(win);
        m_o[d] = o;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_sh[d] = 0;
            m_ac[d] = 0;
            m_acc[d] = 0;
            m_o[d] = '0;
        end
    endtask

    task automatic step(input bit m, input bit v, input int a, input int u, input bit l = 0,
                        input int w = 0, input bit s = 0, input bit c = 0, input bit dr = 0);
        trio_t e;
        mode = m; iv = v; left = DW'(a); up = AW'(u);
        wl = l; win = DW'(w); ws = s; clr = c; drn = dr;
        for (int d = 0; d < 3; d++) begin
            model(d);
            e[d] = m_o[d];
        end
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string n, input int d, input longint a, input longint e);
        n_vec++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d", n, d, a, e);
        end
    endtask

    initial begin
        trio_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL scoreboard: output cycle with no expected entry");
                end else begin
                    e = q.pop_front();
                    for (int d = 0; d < 3; d++) begin
                        n_vec++;
                        if (act[d] !== e[d]) begin
                            n_bad++;
                            $display("FAIL out dut%0d: got/exp valid %0b/%0b right %0d/%0d down %0d/%0d acc_out_valid %0b/%0b acc_out %0d/%0d ovf %0b/%0b",
                                     d, act[d].ov, e[d].ov, act[d].orr, e[d].orr, act[d].od, e[d].od,
                                     act[d].aov, e[d].aov, act[d].ao, e[d].ao, act[d].ovf, e[d].ovf);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit rm;
        int u, sel;
        model_reset();
        #1 rst = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) chk("reset_state", d, longint'(act[d]), 0);
        @(negedge clk);
        #1 rst = 1'b1;
        // WS basic MAC and hold on invalid
        step(0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 5, 100);
        chk("ws_out_down", 0, act[0].od, 115);
        chk("ws_out_right", 0, act[0].orr, 5);
        step(0, 0, 0, 0);
        chk("ws_hold_valid", 0, act[0].ov, 0);
        chk("ws_hold_down", 0, act[0].od, 115);
        // Double buffer
        step(0, 0, 0, 0, 1, 7);
        step(0, 1, 4, 0);
        chk("shadow_not_active", 0, act[0].od, 12);
        step(0, 0, 0, 0, 1, 9, 1);
        step(0, 1, -2, 0);
        chk("swap_old_shadow", 0, longint'($signed(act[0].od)), -14);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 0);
        chk("shadow_new", 0, act[0].od, 9);
        // Saturation vs wrap
        step(0, 0, 0, 0, 1, 10);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 10, 32760);
        chk("sat_pos", 0, act[0].od, 32767);
        chk("sat_ovf", 0, act[0].ovf, 1);
        chk("wrap_pos", 1, longint'($signed(act[1].od)), -32676);
        chk("wrap_ovf", 1, act[1].ovf, 1);
        chk("unsigned_no_ovf", 2, act[2].ovf, 0);
        step(0, 1, -10, -32760);
        chk("sat_neg", 0, longint'($signed(act[0].od)), -32768);
        step(0, 1, 255, 65535);
        step(0, 1, 0, 0);
        chk("ovf_sticky", 0, act[0].ovf, 1);
        chk("unsigned_sat", 2, act[2].ovf, 1);
        step(0, 1, 10, 32760, 0, 0, 0, 1);
        chk("ovf_set_beats_clear", 0, act[0].ovf, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_cleared", 0, act[0].ovf, 0);
        // OS stream and drain
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 2, 3);
        step(1, 1, 4, 5);
        step(1, 1, -1, 6);
        chk("os_down_passthru", 0, act[0].od, 6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("os_drain_value", 0, act[0].ao, 20);
        chk("os_drain_pulse", 0, act[0].aov, 1);
        step(1, 0, 0, 0);
        chk("os_pulse_end", 0, act[0].aov, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("os_drain_cleared", 0, act[0].ao, 0);
        // Drain together with valid
        step(1, 1, 2, 5);
        step(1, 1, 3, 3, 0, 0, 0, 0, 1);
        chk("os_drain_pre", 0, act[0].ao, 10);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("os_drain_restart", 0, act[0].ao, 9);
        // Asynchronous reset between edges
        step(1, 1, 3, 4);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("async_reset", d, longint'(act[d]), 0);
        model_reset();
        mode = 0; iv = 0; left = '0; up = '0; wl = 0; win = '0; ws = 0; clr = 0; drn = 0;
        @(negedge clk);
        #1 rst = 1'b1;
        step(1, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("post_reset_acc", 0, act[0].ao, 1);
        step(0, 0, 0, 0);
        // Randomised traffic; mode flips only on idle cycles
        rm = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bit v;
            v = $urandom_range(0, 3) != 0;
            if (!v && $urandom_range(0, 2) == 0) rm = ~rm;
            sel = $urandom_range(0, 3);
            u = sel == 0 ? int'($urandom) : sel == 1 ? 32'h7F00 + $urandom_range(0, 255)
              : sel == 2 ? 32'h8000 + $urandom_range(0, 255) : 32'hFF00 + $urandom_range(0, 255);
            step(rm, v, int'($urandom), u, $urandom_range(0, 3) == 0, int'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 0, q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
